conv_layer_sequencer: RTL

//  Host-side sequencer for the convolution accelerator register/stream interface. On one start

---
 rtl/conv_accel_pkg.sv | 43 ++++
 rtl/seq_watchdog.sv | 33 +++
 rtl/conv_layer_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_accel_pkg.sv
// Shared constants and types for the conv layer sequencer: register map, opcodes, expected beats, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package conv_accel_pkg;

    localparam int LAYER_W = 2;

    // Conv interface register map
    localparam logic [2:0] REG_CMD   = 3'd0;
    localparam logic [2:0] REG_LAYER = 3'd1;
    localparam logic [2:0] REG_SETS  = 3'd2;

    localparam logic [1:0] OPC_START = 2'b00;

    // Output-stream beats each layer produces for one run
    localparam logic [31:0] EXP_BEATS_L0 = 32'd196;
    localparam logic [31:0] EXP_BEATS_L1 = 32'd25;
    localparam logic [31:0] EXP_BEATS_L2 = 32'd1;

    // err_status bit positions
    localparam int ERR_BAD_CFG  = 0;
    localparam int ERR_MISMATCH = 1;
    localparam int ERR_TIMEOUT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SETS,
        ST_GO,
        ST_RUN,
        ST_NEXT,
        ST_DONE
    } seq_state_t;

    function automatic logic [31:0] expected_beats(input logic [LAYER_W-1:0] layer);
        case (layer)
            2'd0:    return EXP_BEATS_L0;
            2'd1:    return EXP_BEATS_L1;
            default: return EXP_BEATS_L2;
        endcase
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Stall watchdog for the RUN state; built only when SEQ_TIMEOUT_EN is defined.
// Latency: expired asserts combinationally in the TIMEOUT_CYCLES-th consecutive beat-free RUN cycle.
// Backpressure: none; observes run/beat only.
`ifdef SEQ_TIMEOUT_EN
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic beat,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count beat-free cycles while running; leaving RUN or any beat restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (!run || beat) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = run && !beat && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/conv_layer_sequencer.sv
// Runs conv layers first..last: three register writes per layer (select, sets, start), then watches the output stream to TLAST.
// Latency: first write 1 cycle after an accepted start, writes on 3 consecutive cycles; done pulses 2 cycles after the final TLAST beat.
// Backpressure: none exerted (stream is monitored only); optional RUN stall timeout when SEQ_TIMEOUT_EN is defined.
module conv_layer_sequencer
    import conv_accel_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_LAYERS         = 3,
    parameter int TIMEOUT_CYCLES     = 1000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_start,
    input  logic                          cmd_abort,
    input  logic [LAYER_W-1:0]            cmd_first_layer,
    input  logic [LAYER_W-1:0]            cmd_last_layer,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_sets_l0,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_sets_l1,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_sets_l2,
    output logic [2:0]                    cl_waddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cl_wdata,
    output logic                          cl_we,
    input  logic                          mon_tvalid,
    input  logic                          mon_tready,
    input  logic                          mon_tlast,
    output logic                          busy,
    output logic                          done,
    output logic [LAYER_W-1:0]            cur_layer,
    output logic [31:0]                   beat_count,
    output logic [2:0]                    err_status
);

    localparam int DW = C_S_AXI_DATA_WIDTH;

    seq_state_t         state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               we_q, we_d;
    logic [2:0]         waddr_q, waddr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [31:0]        beat_q, beat_d;
    logic [2:0]         err_q, err_d;

    logic               beat;
    logic               cfg_bad;
    logic               timeout_hit;
    logic [31:0]        exp_beats;
    logic [32:0]        beat_inc;
    logic [DW-1:0]      sets_arr [4];

    assign beat      = mon_tvalid & mon_tready;
    assign exp_beats = expected_beats(layer_q);
    assign beat_inc  = {1'b0, beat_q} + 33'd1;

    // Index 3 is never a valid layer; it reads as zero so it can never look configured
    assign sets_arr[0] = cmd_sets_l0;
    assign sets_arr[1] = cmd_sets_l1;
    assign sets_arr[2] = cmd_sets_l2;
    assign sets_arr[3] = '0;

`ifdef SEQ_TIMEOUT_EN
    logic in_run;
    assign in_run = (state_q == ST_RUN);

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .run    (in_run),
        .beat   (beat),
        .expired(timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    // Reject a start whose layer range is inverted, out of range, or selects a layer with zero input sets
    always_comb begin
        cfg_bad = (cmd_first_layer > cmd_last_layer)
               || (int'(cmd_first_layer) >= NUM_LAYERS)
               || (int'(cmd_last_layer) >= NUM_LAYERS);
        for (int l = 0; l < 3; l++) begin
            if ((LAYER_W'(l) >= cmd_first_layer) && (LAYER_W'(l) <= cmd_last_layer)
                && (sets_arr[l] == '0)) begin
                cfg_bad = 1'b1;
            end
        end
    end

    // Next state plus registered outputs; write port and flags follow the state being entered
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        err_d   = err_q;
        beat_d  = beat_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    if (cfg_bad) begin
                        err_d[ERR_BAD_CFG] = 1'b1;
                    end else begin
                        err_d   = '0;
                        layer_d = cmd_first_layer;
                        state_d = ST_SEL;
                    end
                end
            end
            ST_SEL:  state_d = ST_SETS;
            ST_SETS: state_d = ST_GO;
            ST_GO: begin
                beat_d  = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (beat) begin
                    if (beat_q != '1) begin
                        beat_d = beat_inc[31:0];
                    end
                    if (mon_tlast) begin
                        if (beat_inc != {1'b0, exp_beats}) begin
                            err_d[ERR_MISMATCH] = 1'b1;
                        end
                        state_d = ST_NEXT;
                    end
                end else if (timeout_hit) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_IDLE;
                end
            end
            ST_NEXT: begin
                if (layer_q == cmd_last_layer) begin
                    state_d = ST_DONE;
                end else begin
                    layer_d = layer_q + 1'b1;
                    state_d = ST_SEL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything but leaves the sticky errors and layer untouched
        if (cmd_abort) begin
            state_d = ST_IDLE;
            layer_d = layer_q;
            err_d   = err_q;
        end

        case (state_d)
            ST_SEL: begin
                we_d    = 1'b1;
                waddr_d = REG_LAYER;
                wdata_d = DW'(3'b001 << layer_d);
            end
            ST_SETS: begin
                we_d    = 1'b1;
                waddr_d = REG_SETS;
                wdata_d = sets_arr[layer_d];
            end
            ST_GO: begin
                we_d    = 1'b1;
                waddr_d = REG_CMD;
                wdata_d = DW'(OPC_START);
            end
            default: ;
        endcase

        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            beat_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    assign cl_we      = we_q;
    assign cl_waddr   = waddr_q;
    assign cl_wdata   = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cur_layer  = layer_q;
    assign beat_count = beat_q;
    assign err_status = err_q;

endmodule
